inv_mix_columns_mc: RTL and testbench

INV_MIX_COLUMNS_MC -- requirements
Module: inv_mix_columns_mc

---
 rtl/inv_mix_columns_mc.sv | 139 +++++++++++++
 tb/tb_inv_mix_columns_mc.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_mix_columns_mc.sv
// AES InvMixColumns engine, multi-cycle.
// Accepts one 128-bit state, transforms cols_per_cycle_p columns per BUSY
// cycle in place, then presents the result until the consumer takes it.
// Ports:
//   clk_i          clock, rising edge
//   reset_n_i      asynchronous active-low reset
//   v_i / ready_o  input block handshake
//   block_i        state to invert, column c at bits [127-32c -: 32]
//   v_o / yumi_i   result handshake (valid-then-yumi)
//   mixed_block_o  InvMixColumns result, meaningful while v_o is high
module inv_mix_columns_mc #(
    parameter int unsigned cols_per_cycle_p = 1
) (
    input  logic         clk_i,
    input  logic         reset_n_i,
    input  logic         v_i,
    output logic         ready_o,
    input  logic [127:0] block_i,
    output logic         v_o,
    input  logic         yumi_i,
    output logic [127:0] mixed_block_o
);

    localparam int unsigned num_cols_lp = 4;
    localparam int unsigned col_w_lp    = 32;
    localparam int unsigned cnt_w_lp    = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [cnt_w_lp-1:0]   cnt_q, cnt_d;
    logic [col_w_lp-1:0]   col_q [num_cols_lp];
    logic [col_w_lp-1:0]   col_d [num_cols_lp];
    logic                  ready_q, ready_d;
    logic                  v_q, v_d;

    // Multiply by x in GF(2^8) modulo 0x11b.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // One column through the inverse MixColumns matrix; byte 0 is the MSB.
    function automatic logic [31:0] inv_col(input logic [31:0] c);
        logic [7:0] a  [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = c[31-8*i -: 8];
            x2    = xtime(a[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    // State, counter, working register and handshake flops.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            v_q     <= 1'b0;
            for (int i = 0; i < int'(num_cols_lp); i++) begin
                col_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            v_q     <= v_d;
            for (int i = 0; i < int'(num_cols_lp); i++) begin
                col_q[i] <= col_d[i];
            end
        end
    end

    // Next-state logic; handshake flops follow the next state so that
    // ready_o/v_o always agree with the state they describe.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        for (int i = 0; i < int'(num_cols_lp); i++) begin
            col_d[i] = col_q[i];
        end

        unique case (state_q)
            IDLE: begin
                // ready_q is low for the first cycle after reset release
                if (ready_q && v_i) begin
                    for (int i = 0; i < int'(num_cols_lp); i++) begin
                        col_d[i] = block_i[127-32*i -: 32];
                    end
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // cnt_q is always a multiple of cols_per_cycle_p, so no wrap here
                for (int unsigned j = 0; j < cols_per_cycle_p; j++) begin
                    col_d[cnt_q + cnt_w_lp'(j)] = inv_col(col_q[cnt_q + cnt_w_lp'(j)]);
                end
                cnt_d = cnt_q + cnt_w_lp'(cols_per_cycle_p);
                if (cnt_q == cnt_w_lp'(num_cols_lp - cols_per_cycle_p)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (yumi_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
        v_d     = (state_d == DONE);
    end

    assign ready_o       = ready_q;
    assign v_o           = v_q;
    assign mixed_block_o = {col_q[0], col_q[1], col_q[2], col_q[3]};

endmodule

// File: tb/tb_inv_mix_columns_mc.sv
// Bench for inv_mix_columns_mc: three instances (1, 2 and 4 columns per
// cycle) checked every cycle against a transaction-level reference model.
module tb_inv_mix_columns_mc;

    logic         clk;
    logic         rst_n;
    logic         v_i     [3];
    logic         ready_o [3];
    logic [127:0] blk_i   [3];
    logic         v_o     [3];
    logic         yumi_i  [3];
    logic [127:0] mixed_o [3];

    int errors = 0;
    int checks = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        inv_mix_columns_mc #(.cols_per_cycle_p(1 << g)) u_dut (
            .clk_i        (clk),
            .reset_n_i    (rst_n),
            .v_i          (v_i[g]),
            .ready_o      (ready_o[g]),
            .block_i      (blk_i[g]),
            .v_o          (v_o[g]),
            .yumi_i       (yumi_i[g]),
            .mixed_block_o(mixed_o[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Textbook shift-and-add GF(2^8) multiply.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    // Circulant matrix product on every column; inv selects InvMixColumns.
    function automatic logic [127:0] mix(input logic [127:0] blk, input bit inv);
        logic [7:0]   row0 [4];
        logic [127:0] res = '0;
        logic [7:0]   acc;
        if (inv) row0 = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     row0 = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int i = 0; i < 4; i++) begin
                    acc ^= gmul(row0[(i - r + 4) % 4], blk[127-32*c-8*i -: 8]);
                end
                res[127-32*c-8*r -: 8] = acc;
            end
        end
        return res;
    endfunction

    function automatic int n_of(input int k);
        return 4 >> k;
    endfunction

    task automatic check(input string name, input int k,
                         input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[inst %0d]: got %h, expected %h", name, k, act, exp);
        end
    endtask

    // Reference model state per instance
    bit           m_rdy  [3];
    bit           m_hold [3];
    int           m_wait [3];
    logic [127:0] m_res  [3];

    task automatic send(input int k, input logic [127:0] blk);
        int t = 0;
        while (!ready_o[k] && t < 50) begin
            @(posedge clk); #1; t++;
        end
        if (t >= 50) check("send_timeout", k, 128'd0, 128'd1);
        v_i[k]   = 1'b1;
        blk_i[k] = blk;
        @(posedge clk); #1;
        v_i[k]   = 1'b0;
    endtask

    task automatic get(input int k, input int hold, output logic [127:0] res);
        int t = 0;
        while (!v_o[k] && t < 50) begin
            @(posedge clk); #1; t++;
        end
        if (t >= 50) check("get_timeout", k, 128'd0, 128'd1);
        repeat (hold) begin
            @(posedge clk); #1;
        end
        res       = mixed_o[k];
        yumi_i[k] = 1'b1;
        @(posedge clk); #1;
        yumi_i[k] = 1'b0;
    endtask

    task automatic xfer(input int k, input logic [127:0] blk, input int hold,
                        output logic [127:0] res);
        send(k, blk);
        get(k, hold, res);
    endtask

    initial begin
        logic [127:0] res;
        logic [127:0] blocks [6];
        logic [127:0] orig;
        int           m, cyc, last, t;
        bit           acc;

        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            v_i[k] = 1'b0; yumi_i[k] = 1'b0; blk_i[k] = '0;
            m_rdy[k] = 1'b0; m_hold[k] = 1'b0; m_wait[k] = 0; m_res[k] = '0;
        end

        // Per-cycle comparison against the model, sampled on the falling edge.
        fork
            forever begin
                @(negedge clk);
                for (int k = 0; k < 3; k++) begin
                    if (!rst_n) begin
                        check("rst_ready", k, 128'(ready_o[k]), 128'd0);
                        check("rst_v",     k, 128'(v_o[k]),     128'd0);
                        check("rst_work",  k, mixed_o[k],       128'd0);
                        m_rdy[k] = 1'b0; m_hold[k] = 1'b0; m_wait[k] = 0;
                    end else begin
                        check("ready", k, 128'(ready_o[k]), 128'(m_rdy[k]));
                        check("v_o",   k, 128'(v_o[k]), 128'(m_hold[k] && m_wait[k] == 0));
                        if (m_hold[k] && m_wait[k] == 0)
                            check("result", k, mixed_o[k], m_res[k]);
                        if (m_rdy[k] && v_i[k]) begin
                            m_hold[k] = 1'b1; m_wait[k] = n_of(k);
                            m_res[k]  = mix(blk_i[k], 1'b1); m_rdy[k] = 1'b0;
                        end else if (m_hold[k] && m_wait[k] > 0) begin
                            m_wait[k]--;
                        end else if (m_hold[k] && yumi_i[k]) begin
                            m_hold[k] = 1'b0; m_rdy[k] = 1'b1;
                        end else if (!m_hold[k]) begin
                            m_rdy[k] = 1'b1;
                        end
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Pin the model to hand-computed values.
        check("pin_fips", 0, mix(128'h5f72641557f5bc92f7be3b291db9f91a, 1'b1),
              128'h6353e08c0960e104cd70b751bacad0e7);
        check("pin_col", 0, mix({4{32'h8e4da1bc}}, 1'b1), {4{32'hdb135345}});
        check("pin_fwd", 0, mix(128'h6353e08c0960e104cd70b751bacad0e7, 1'b0),
              128'h5f72641557f5bc92f7be3b291db9f91a);

        for (int k = 0; k < 3; k++) begin
            xfer(k, 128'h5f72641557f5bc92f7be3b291db9f91a, 0, res);
            check("fips_vec", k, res, 128'h6353e08c0960e104cd70b751bacad0e7);
            xfer(k, {4{32'h8e4da1bc}}, 0, res);
            check("col_vec", k, res, {4{32'hdb135345}});
            xfer(k, {4{32'hc6c6c6c6}}, 0, res);
            check("c6_vec", k, res, {4{32'hc6c6c6c6}});
            xfer(k, 128'd0, 0, res);
            check("zero_vec", k, res, 128'd0);

            // Hold result 10 cycles while v_i pulses with junk during BUSY/DONE.
            send(k, 128'h00112233445566778899aabbccddeeff);
            v_i[k] = 1'b1; blk_i[k] = {4{32'hdeadbeef}};
            t = 0;
            while (!v_o[k] && t < 50) begin
                @(posedge clk); #1; t++;
            end
            repeat (10) begin
                @(posedge clk); #1;
            end
            v_i[k] = 1'b0;
            get(k, 0, res);
            check("hold_vec", k, res, mix(128'h00112233445566778899aabbccddeeff, 1'b1));

            // Back-to-back with v_i and yumi_i held high.
            for (int i = 0; i < 6; i++) blocks[i] = {$urandom, $urandom, $urandom, $urandom};
            m = 0; cyc = 0; last = 0;
            v_i[k] = 1'b1; yumi_i[k] = 1'b1; blk_i[k] = blocks[0];
            while (m < 6 && cyc < 200) begin
                acc = ready_o[k];
                @(posedge clk); #1;
                cyc++;
                if (acc) begin
                    if (m > 0) check("b2b_period", k, 128'(cyc - last), 128'(n_of(k) + 2));
                    last = cyc;
                    m++;
                    if (m < 6) blk_i[k] = blocks[m];
                    else       v_i[k] = 1'b0;
                end
            end
            v_i[k] = 1'b0;
            check("b2b_count", k, 128'(m), 128'd6);
            t = 0;
            while (!ready_o[k] && t < 50) begin
                @(posedge clk); #1; t++;
            end
            yumi_i[k] = 1'b0;
        end

        // Reset during the second BUSY cycle.
        for (int k = 0; k < 2; k++) begin
            send(k, 128'h0f0e0d0c0b0a09080706050403020100);
            @(posedge clk); #1;
            rst_n = 1'b0;
            repeat (2) begin
                @(posedge clk); #1;
            end
            rst_n = 1'b1;
            @(posedge clk); #1;
            check("ready_after_rst", k, 128'(ready_o[k]), 128'd1);
            xfer(k, 128'h5f72641557f5bc92f7be3b291db9f91a, 0, res);
            check("post_rst_vec", k, res, 128'h6353e08c0960e104cd70b751bacad0e7);
        end

        // Round trip through the forward transform.
        for (int i = 0; i < 1000; i++) begin
            orig = {$urandom, $urandom, $urandom, $urandom};
            xfer(0, mix(orig, 1'b0), 0, res);
            check("round_trip", 0, res, orig);
        end
        for (int i = 0; i < 100; i++) begin
            orig = {$urandom, $urandom, $urandom, $urandom};
            xfer(2, mix(orig, 1'b0), 0, res);
            check("round_trip", 2, res, orig);
        end

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
